// File: rtl/bit_op_pkg.sv
// Package: bit_op_pkg
// Purpose : Shared constants, FSM state type and the operand-combining helper
//           for the bit_op_arbiter block.
// Contents:
//   N_REQ, W_A, W_B, W_C, W_CNT : requester count and datapath widths
//   ID_W                        : width of a requester index
//   state_e                     : EMPTY (no result held) / FULL (result held)
//   and_op()                    : zero-extends both operands to W_C, then ANDs them
package bit_op_pkg;

  localparam int N_REQ = 4;
  localparam int W_A   = 2;
  localparam int W_B   = 3;
  localparam int W_C   = 4;
  localparam int W_CNT = 8;
  localparam int ID_W  = $clog2(N_REQ);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // Both operands are widened before the AND, so any result bit above
  // min(W_A, W_B) is always 0.
  function automatic logic [W_C-1:0] and_op(input logic [W_A-1:0] a,
                                            input logic [W_B-1:0] b);
    return W_C'(a) & W_C'(b);
  endfunction

endpackage

// File: rtl/bit_op_arbiter_if.sv
// Interface: bit_op_arbiter_if
// Purpose  : Bundles the requester-side operand/grant signals and the
//            consumer-side result handshake of bit_op_arbiter.
// Signals  :
//   pi_req     [N_REQ]       per-requester request
//   pi_a       [N_REQ*W_A]   packed operand a, requester i at [i*W_A +: W_A]
//   pi_b       [N_REQ*W_B]   packed operand b, requester i at [i*W_B +: W_B]
//   po_gnt     [N_REQ]       one-hot grant
//   po_c       [W_C]         result
//   po_c_valid               result valid
//   po_c_id    [ID_W]        owner of po_c
//   pi_c_ready               consumer ready
//   po_txn_cnt [W_CNT]       accepted-result counter
// Modports : slave = the arbiter itself, master = the environment around it.
interface bit_op_arbiter_if;
  import bit_op_pkg::*;

  logic [N_REQ-1:0]     pi_req;
  logic [N_REQ*W_A-1:0] pi_a;
  logic [N_REQ*W_B-1:0] pi_b;
  logic [N_REQ-1:0]     po_gnt;
  logic [W_C-1:0]       po_c;
  logic                 po_c_valid;
  logic [ID_W-1:0]      po_c_id;
  logic                 pi_c_ready;
  logic [W_CNT-1:0]     po_txn_cnt;

  modport slave (
    input  pi_req, pi_a, pi_b, pi_c_ready,
    output po_gnt, po_c, po_c_valid, po_c_id, po_txn_cnt
  );

  modport master (
    output pi_req, pi_a, pi_b, pi_c_ready,
    input  po_gnt, po_c, po_c_valid, po_c_id, po_txn_cnt
  );

endinterface

// File: rtl/rr_arbiter.sv
// Module : rr_arbiter
// Purpose: Purely combinational round-robin pick. Returns the first asserted
//          request at or after ptr, searching upward and wrapping.
// Ports  :
//   req [N]   request vector
//   ptr [IW]  highest-priority index for this cycle
//   gnt [N]   one-hot grant (all zero when req is zero)
//   idx [IW]  binary index of the grant (0 when req is zero)
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] j;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    j     = '0;
    found = 1'b0;
    // Walk N positions starting at ptr; the modulo handles non-power-of-two N.
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/bit_op_arbiter.sv
// Module : bit_op_arbiter
// Purpose: One registered AND unit (c = a & b) shared by N_REQ requesters via
//          a round-robin arbiter. The result is presented on a valid/ready port
//          tagged with the winner's id; a count of accepted results is kept.
// Ports  :
//   clk  rising-edge clock
//   rst  synchronous reset, active-high
//   bus  bit_op_arbiter_if.slave (requests, operands, grant, result handshake,
//        transaction counter)
module bit_op_arbiter
  import bit_op_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  bit_op_arbiter_if.slave   bus
);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [W_C-1:0]   c_q, c_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [W_CNT-1:0] cnt_q, cnt_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]  arb_idx;
  logic [W_A-1:0]   a_sel;
  logic [W_B-1:0]   b_sel;
  logic             c_valid;
  logic             drain;
  logic             can_accept;
  logic             grant_en;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (ID_W)
  ) u_rr_arbiter (
    .req (bus.pi_req),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign c_valid    = (state_q == FULL);
  assign drain      = c_valid & bus.pi_c_ready;
  // A held result that is leaving this cycle frees the slot, giving
  // back-to-back results with no bubble.
  assign can_accept = (state_q == EMPTY) | drain;
  assign grant_en   = can_accept & (|bus.pi_req) & ~rst;

  // Operand mux with constant slice bounds per requester.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_idx == ID_W'(i)) begin
        a_sel = bus.pi_a[i*W_A +: W_A];
        b_sel = bus.pi_b[i*W_B +: W_B];
      end
    end
  end

  always_comb begin
    // NOTE: every _d starts from its _q value, so no path leaves it unassigned
    // and no latch is inferred.
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    c_d      = c_q;
    id_d     = id_q;
    cnt_d    = cnt_q;

    if (drain) begin
      state_d = EMPTY;
      cnt_d   = cnt_q + 1'b1;  // wraps naturally at 2^W_CNT
    end

    if (grant_en) begin
      state_d  = FULL;
      c_d      = and_op(a_sel, b_sel);
      id_d     = arb_idx;
      rr_ptr_d = (arb_idx == ID_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q  <= EMPTY;
      rr_ptr_q <= '0;
      c_q      <= '0;
      id_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      c_q      <= c_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.po_gnt     = grant_en ? arb_gnt : '0;
  assign bus.po_c       = c_q;
  assign bus.po_c_valid = c_valid;
  assign bus.po_c_id    = id_q;
  assign bus.po_txn_cnt = cnt_q;

endmodule

// File: tb/tb_bit_op_arbiter.sv
// Testbench: tb_bit_op_arbiter
// Purpose  : Directed and randomized stimulus for bit_op_arbiter, checked every
//            cycle against a behavioural model of the sharing rules (who wins,
//            what the result is, when it is held, how many were accepted).
module tb_bit_op_arbiter;
  import bit_op_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bit_op_arbiter_if bus ();

  bit_op_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  int m_ptr;
  int m_c;
  int m_id;
  int m_cnt;
  bit m_held;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Index of the requester that should win this cycle, or -1 for no grant.
  function automatic int exp_idx();
    int r;
    int j;
    r = int'(bus.pi_req);
    if (rst === 1'b1) return -1;
    if (m_held && bus.pi_c_ready !== 1'b1) return -1;
    for (int k = 0; k < N_REQ; k++) begin
      j = (m_ptr + k) % N_REQ;
      if (((r >> j) & 1) != 0) return j;
    end
    return -1;
  endfunction

  task automatic model_edge(input int gi);
    int a;
    int b;
    if (rst === 1'b1) begin
      m_held = 1'b0;
      m_c    = 0;
      m_id   = 0;
      m_cnt  = 0;
      m_ptr  = 0;
    end else begin
      if (m_held && bus.pi_c_ready === 1'b1) begin
        m_cnt  = (m_cnt + 1) % (1 << W_CNT);
        m_held = 1'b0;
      end
      if (gi >= 0) begin
        a      = (int'(bus.pi_a) >> (gi * W_A)) & ((1 << W_A) - 1);
        b      = (int'(bus.pi_b) >> (gi * W_B)) & ((1 << W_B) - 1);
        m_c    = a & b;
        m_id   = gi;
        m_ptr  = (gi + 1) % N_REQ;
        m_held = 1'b1;
      end
    end
  endtask

  // Inputs are set by the caller after a falling edge; outputs are compared
  // mid-low-phase, then the model advances across the rising edge.
  task automatic step();
    int gi;
    #1;
    gi = exp_idx();
    check("gnt",   32'(bus.po_gnt), (gi >= 0) ? (32'd1 << gi) : 32'd0);
    check("valid", 32'(bus.po_c_valid), 32'(m_held));
    check("c",     32'(bus.po_c), 32'(m_c));
    check("id",    32'(bus.po_c_id), 32'(m_id));
    check("cnt",   32'(bus.po_txn_cnt), 32'(m_cnt));
    @(posedge clk);
    model_edge(gi);
    @(negedge clk);
  endtask

  task automatic rand_operands();
    bus.pi_a = (N_REQ*W_A)'($urandom());
    bus.pi_b = (N_REQ*W_B)'($urandom());
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    int start_cnt;
    int hold_c;
    int hold_id;
    int prev_cnt;

    m_ptr  = 0;
    m_c    = 0;
    m_id   = 0;
    m_cnt  = 0;
    m_held = 1'b0;

    // Reset hold with every requester asking.
    rst            = 1'b1;
    bus.pi_req     = '1;
    bus.pi_c_ready = 1'b1;
    rand_operands();
    @(negedge clk);
    repeat (3) step();

    // Single request from requester 2: 2'b11 & 3'b101 = 4'b0001.
    rst        = 1'b0;
    bus.pi_req = '0;
    bus.pi_req[2] = 1'b1;
    rand_operands();
    bus.pi_a[2*W_A +: W_A] = W_A'(3);
    bus.pi_b[2*W_B +: W_B] = W_B'(5);
    #1;
    check("t2_gnt", 32'(bus.po_gnt), 32'h4);
    step();
    bus.pi_req = '0;
    #1;
    check("t2_c",     32'(bus.po_c), 32'h1);
    check("t2_id",    32'(bus.po_c_id), 32'd2);
    check("t2_valid", 32'(bus.po_c_valid), 32'd1);
    step();

    // Lone requester 3 moves the pointer back to 0.
    bus.pi_req = '0;
    bus.pi_req[N_REQ-1] = 1'b1;
    step();

    // Round-robin over all requesters, ready held high.
    bus.pi_req = '1;
    start_cnt  = m_cnt + (m_held ? 1 : 0);
    for (int k = 0; k < 8; k++) begin
      rand_operands();
      step();
      check("t3_id",    32'(bus.po_c_id), 32'(k % N_REQ));
      check("t3_valid", 32'(bus.po_c_valid), 32'd1);
    end
    bus.pi_req = '0;
    step();
    check("t3_cnt", 32'(bus.po_txn_cnt), 32'((start_cnt + 8) % (1 << W_CNT)));

    // Backpressure: result held for 5 cycles, then drain + grant together.
    bus.pi_req     = '1;
    bus.pi_c_ready = 1'b0;
    rand_operands();
    step();
    hold_c  = m_c;
    hold_id = m_id;
    for (int k = 0; k < 5; k++) begin
      rand_operands();
      step();
      check("t4_c_hold",  32'(bus.po_c), 32'(hold_c));
      check("t4_id_hold", 32'(bus.po_c_id), 32'(hold_id));
    end
    bus.pi_c_ready = 1'b1;
    #1;
    check("t4_gnt", 32'(bus.po_gnt), 32'd1 << ((hold_id + 1) % N_REQ));
    step();
    check("t4_id_next", 32'(bus.po_c_id), 32'((hold_id + 1) % N_REQ));
    check("t4_valid",   32'(bus.po_c_valid), 32'd1);

    // Random traffic long enough to wrap the transaction counter.
    for (int k = 0; k < 600; k++) begin
      bus.pi_req     = N_REQ'($urandom());
      bus.pi_c_ready = ($urandom_range(0, 3) != 0);
      rand_operands();
      prev_cnt = m_cnt;
      step();
      if (prev_cnt == (1 << W_CNT) - 1 && m_cnt == 0)
        check("t5_wrap", 32'(bus.po_txn_cnt), 32'd0);
    end

    // Reset while a result is stalled.
    bus.pi_req     = '1;
    bus.pi_c_ready = 1'b0;
    step();
    check("t6_valid_pre", 32'(bus.po_c_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_valid_post", 32'(bus.po_c_valid), 32'd0);
    check("t6_cnt_post",   32'(bus.po_txn_cnt), 32'd0);
    bus.pi_c_ready = 1'b1;
    #1;
    check("t6_gnt", 32'(bus.po_gnt), 32'h1);
    step();
    check("t6_id", 32'(bus.po_c_id), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
